gecikmeli_bellek: RTL and testbench

Parametrised successor to the single-cycle main memory: a word-addressed RAM behind a valid/ready request and response handshake with a programmable access latency, byte write strobes, and an out-of-range error flag. It sits between `islemci` and the memory space at `BELLEK_ADRES`. It produces genuine multi-cycle memory stalls, so the processor's `ilerle_cmb` advance logic is exercised under every latency setting.

---
 rtl/gecikmeli_bellek_pkg.sv | 37 +++
 rtl/gecikmeli_bellek_if.sv | 32 +++
 rtl/gecikmeli_bellek_bayt_maskeli_yazma.sv | 19 +
 rtl/gecikmeli_bellek.sv | 153 +++++++++++++++
 tb/tb_gecikmeli_bellek.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gecikmeli_bellek_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bellek_paket
//  Brief    : Shared state encoding, default base address and address helpers
//             for the latency-programmable word memory.
//  Revision : 1.0 - initial release
// ============================================================================
package bellek_paket;

    localparam logic [31:0] VARSAYILAN_BELLEK_ADRES = 32'h8000_0000;
    localparam int          SAYAC_BIT               = 8;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        CEVAP = 2'd2
    } durum_t;

    // Helpers work on 64-bit operands so any address width up to 64 fits.
    function automatic logic [63:0] adres_satir_idx(
        input logic [63:0] adres,
        input logic [63:0] taban,
        input int unsigned bayt_log2
    );
        return (adres - taban) >> bayt_log2;
    endfunction

    function automatic logic adres_gecerli(
        input logic [63:0] adres,
        input logic [63:0] taban,
        input logic [63:0] boyut
    );
        return (adres >= taban) && ((adres - taban) < boyut);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gecikmeli_bellek_if.sv
`default_nettype none
// ============================================================================
//  Module   : gecikmeli_bellek_if
//  Brief    : Request/response handshake bundle between a requester and the
//             latency-programmable memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface gecikmeli_bellek_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
);
    logic                    istek_gecerli;
    logic                    istek_hazir;
    logic [ADRES_BIT-1:0]    istek_adres;
    logic                    istek_yaz;
    logic [VERI_BIT-1:0]     istek_veri;
    logic [VERI_BIT/8-1:0]   istek_maske;
    logic                    cevap_gecerli;
    logic [VERI_BIT-1:0]     cevap_veri;
    logic                    cevap_hata;

    modport master (
        output istek_gecerli, istek_adres, istek_yaz, istek_veri, istek_maske,
        input  istek_hazir, cevap_gecerli, cevap_veri, cevap_hata
    );

    modport slave (
        input  istek_gecerli, istek_adres, istek_yaz, istek_veri, istek_maske,
        output istek_hazir, cevap_gecerli, cevap_veri, cevap_hata
    );
endinterface
`default_nettype wire

// File: rtl/gecikmeli_bellek_bayt_maskeli_yazma.sv
`default_nettype none
// ============================================================================
//  Module   : bayt_maskeli_yazma
//  Brief    : Combinational per-byte merge of an old row with new write data.
//  Revision : 1.0 - initial release
// ============================================================================
module bayt_maskeli_yazma #(
    parameter int VERI_BIT = 32
) (
    input  wire logic [VERI_BIT-1:0]   i_eski,
    input  wire logic [VERI_BIT-1:0]   i_yeni,
    input  wire logic [VERI_BIT/8-1:0] i_maske,
    output logic      [VERI_BIT-1:0]   o_sonuc
);
    for (genvar b = 0; b < VERI_BIT/8; b++) begin : g_bayt
        assign o_sonuc[8*b +: 8] = i_maske[b] ? i_yeni[8*b +: 8] : i_eski[8*b +: 8];
    end
endmodule
`default_nettype wire

// File: rtl/gecikmeli_bellek.sv
`default_nettype none
// ============================================================================
//  Module   : gecikmeli_bellek
//  Brief    : Word-addressed RAM behind a valid/ready handshake with a
//             programmable access latency, byte strobes and range error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module gecikmeli_bellek
    import bellek_paket::*;
#(
    parameter int                   ADRES_BIT    = 32,
    parameter int                   VERI_BIT     = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = ADRES_BIT'(VARSAYILAN_BELLEK_ADRES),
    parameter int                   SATIR_SAYISI = 1024,
    parameter int                   GECIKME      = 4
) (
    input wire logic            clk,
    input wire logic            rst,
    gecikmeli_bellek_if.slave   bus
);
    localparam int                   c_BAYT       = VERI_BIT / 8;
    localparam int unsigned          c_BAYT_LOG2  = $clog2(c_BAYT);
    localparam int                   c_IDX_BIT    = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
    localparam logic [63:0]          c_BOYUT      = 64'(SATIR_SAYISI) * 64'(c_BAYT);
    localparam logic [SAYAC_BIT-1:0] c_GECIKME_M1 = SAYAC_BIT'(GECIKME - 1);

    logic [VERI_BIT-1:0] bellek [0:SATIR_SAYISI-1];

    durum_t                 durum_q, durum_d;
    logic [SAYAC_BIT-1:0]   sayac_q, sayac_d;
    logic [ADRES_BIT-1:0]   adres_q, adres_d;
    logic                   yaz_q, yaz_d;
    logic [VERI_BIT-1:0]    veri_q, veri_d;
    logic [c_BAYT-1:0]      maske_q, maske_d;
    logic                   istek_hazir_q, istek_hazir_d;
    logic                   cevap_gecerli_q, cevap_gecerli_d;
    logic [VERI_BIT-1:0]    cevap_veri_q, cevap_veri_d;
    logic                   cevap_hata_q, cevap_hata_d;

    logic                   w_adres_gecerli;
    logic [c_IDX_BIT-1:0]   w_satir_idx;
    logic [VERI_BIT-1:0]    w_eski;
    logic [VERI_BIT-1:0]    w_yeni;
    logic                   w_yurut;
    logic                   w_yaz_en;

    // Decode works only on the captured copy, so the request bus may change freely.
    assign w_adres_gecerli = adres_gecerli(64'(adres_q), 64'(BELLEK_ADRES), c_BOYUT);
    assign w_satir_idx     = c_IDX_BIT'(adres_satir_idx(64'(adres_q), 64'(BELLEK_ADRES), c_BAYT_LOG2));
    assign w_eski          = bellek[w_satir_idx];
    assign w_yaz_en        = w_yurut && yaz_q && w_adres_gecerli;

    bayt_maskeli_yazma #(
        .VERI_BIT (VERI_BIT)
    ) u_yazma (
        .i_eski  (w_eski),
        .i_yeni  (veri_q),
        .i_maske (maske_q),
        .o_sonuc (w_yeni)
    );

    always_comb begin
        durum_d         = durum_q;
        sayac_d         = sayac_q;
        adres_d         = adres_q;
        yaz_d           = yaz_q;
        veri_d          = veri_q;
        maske_d         = maske_q;
        istek_hazir_d   = istek_hazir_q;
        cevap_gecerli_d = 1'b0;
        cevap_veri_d    = cevap_veri_q;
        cevap_hata_d    = cevap_hata_q;
        w_yurut         = 1'b0;

        case (durum_q)
            BOSTA: begin
                istek_hazir_d = 1'b1;
                if (bus.istek_gecerli) begin
                    adres_d       = bus.istek_adres;
                    yaz_d         = bus.istek_yaz;
                    veri_d        = bus.istek_veri;
                    maske_d       = bus.istek_maske;
                    sayac_d       = c_GECIKME_M1;
                    durum_d       = BEKLE;
                    istek_hazir_d = 1'b0;
                end
            end
            BEKLE: begin
                if (sayac_q == '0) begin
                    w_yurut         = 1'b1;
                    durum_d         = CEVAP;
                    cevap_gecerli_d = 1'b1;
                    cevap_hata_d    = !w_adres_gecerli;
                    cevap_veri_d    = (!yaz_q && w_adres_gecerli) ? w_eski : '0;
                end else begin
                    sayac_d = sayac_q - 1'b1;
                end
            end
            CEVAP: begin
                durum_d       = BOSTA;
                istek_hazir_d = 1'b1;
                cevap_veri_d  = '0;
                cevap_hata_d  = 1'b0;
            end
            default: begin
                durum_d       = BOSTA;
                istek_hazir_d = 1'b1;
                cevap_veri_d  = '0;
                cevap_hata_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum_q         <= BOSTA;
            sayac_q         <= '0;
            adres_q         <= '0;
            yaz_q           <= 1'b0;
            veri_q          <= '0;
            maske_q         <= '0;
            istek_hazir_q   <= 1'b1;
            cevap_gecerli_q <= 1'b0;
            cevap_veri_q    <= '0;
            cevap_hata_q    <= 1'b0;
        end else begin
            durum_q         <= durum_d;
            sayac_q         <= sayac_d;
            adres_q         <= adres_d;
            yaz_q           <= yaz_d;
            veri_q          <= veri_d;
            maske_q         <= maske_d;
            istek_hazir_q   <= istek_hazir_d;
            cevap_gecerli_q <= cevap_gecerli_d;
            cevap_veri_q    <= cevap_veri_d;
            cevap_hata_q    <= cevap_hata_d;
        end
    end

    // Storage is deliberately unreset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_yaz_en) begin
            bellek[w_satir_idx] <= w_yeni;
        end
    end

    assign bus.istek_hazir   = istek_hazir_q;
    assign bus.cevap_gecerli = cevap_gecerli_q;
    assign bus.cevap_veri    = cevap_veri_q;
    assign bus.cevap_hata    = cevap_hata_q;

endmodule
`default_nettype wire

// File: tb/tb_gecikmeli_bellek.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gecikmeli_bellek
//  Brief    : Directed, table-driven bench for the latency-programmable memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gecikmeli_bellek;

    logic clk = 1'b0;
    logic rst_ana;
    int   cyc = 0;
    int   kontrol_sayisi = 0;
    int   hata_sayisi = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gecikmeli_bellek_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

    gecikmeli_bellek #(
        .ADRES_BIT    (32),
        .VERI_BIT     (32),
        .BELLEK_ADRES (32'h8000_0000),
        .SATIR_SAYISI (1024),
        .GECIKME      (4)
    ) dut (
        .clk (clk),
        .rst (rst_ana),
        .bus (bus)
    );

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gercek=%0h beklenen=%0h", ad, gercek, beklenen);
        end
    endtask

    typedef struct {
        logic        yaz;
        logic [31:0] adres;
        logic [31:0] veri;
        logic [3:0]  maske;
        logic [31:0] bek_veri;
        logic        bek_hata;
    } vektor_t;

    // One full transaction; captures the response and counts stall cycles.
    task automatic islem(input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                         input logic [3:0] maske, output logic [31:0] o_veri, output logic o_hata,
                         output int gecikme, output int darbe, output int dusuk);
        o_veri = '0; o_hata = 1'b0; gecikme = -1; darbe = 0; dusuk = 0;
        @(negedge clk);
        bus.istek_yaz = yaz; bus.istek_adres = adr; bus.istek_veri = veri;
        bus.istek_maske = maske; bus.istek_gecerli = 1'b1;
        @(posedge clk);
        #1;
        bus.istek_gecerli = 1'b0;
        bus.istek_veri    = ~veri;
        bus.istek_adres   = adr ^ 32'h10;
        bus.istek_maske   = ~maske;
        bus.istek_yaz     = ~yaz;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.cevap_gecerli) begin
                darbe++;
                if (darbe == 1) begin
                    o_veri = bus.cevap_veri; o_hata = bus.cevap_hata; gecikme = k;
                end
            end
            if (bus.istek_hazir) break;
            dusuk++;
        end
    endtask

    // Latency sweep on independent instances, requests held valid throughout.
    for (genvar s = 0; s < 3; s++) begin : g_sweep
        localparam int G = (s == 0) ? 1 : ((s == 1) ? 2 : 7);
        logic rst_s;
        bit   bitti = 1'b0;
        gecikmeli_bellek_if #(.ADRES_BIT(32), .VERI_BIT(32)) sbus ();
        gecikmeli_bellek #(.GECIKME(G)) u_dut (.clk(clk), .rst(rst_s), .bus(sbus));

        initial begin
            int          acc;
            int          onceki;
            bit          goruldu;
            logic [31:0] bek;
            rst_s = 1'b0;
            sbus.istek_gecerli = 1'b0; sbus.istek_yaz = 1'b0; sbus.istek_veri = '0;
            sbus.istek_maske = '0; sbus.istek_adres = '0;
            for (int j = 0; j < 5; j++) u_dut.bellek[j*3+1] = 32'h5A00_0000 | 32'(G << 8) | 32'(j);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_s = 1'b1;
            sbus.istek_gecerli = 1'b1;
            onceki = -1;
            for (int j = 0; j < 5; j++) begin
                sbus.istek_adres = 32'h8000_0000 + 32'(4 * (j*3+1));
                bek = 32'h5A00_0000 | 32'(G << 8) | 32'(j);
                goruldu = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    if (sbus.istek_hazir) begin goruldu = 1'b1; break; end
                    @(negedge clk);
                end
                acc = cyc + 1;
                kontrol("sweep_hazir", 64'(goruldu), 64'd1);
                goruldu = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (sbus.cevap_gecerli) begin goruldu = 1'b1; break; end
                end
                kontrol("sweep_cevap_var", 64'(goruldu), 64'd1);
                kontrol("sweep_veri", 64'(sbus.cevap_veri), 64'(bek));
                kontrol("sweep_gecikme", 64'(cyc - acc), 64'(G));
                if (j > 0) kontrol("sweep_aralik", 64'(cyc - onceki), 64'(G + 2));
                onceki = cyc;
            end
            sbus.istek_gecerli = 1'b0;
            bitti = 1'b1;
        end
    end

    initial begin
        vektor_t     tablo [12];
        logic [31:0] r_veri;
        logic        r_hata;
        int          gec, darbe, dusuk;
        bit          goruldu;

        tablo[0]  = '{1'b0, 32'h8000_0200, 32'h0,         4'hF,    32'h0000_0200, 1'b0};
        tablo[1]  = '{1'b1, 32'h8000_0204, 32'h1234_5678, 4'b0101, 32'h0,         1'b0};
        tablo[2]  = '{1'b0, 32'h8000_0204, 32'h0,         4'h0,    32'hFF34_FF78, 1'b0};
        tablo[3]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF,    32'h0,         1'b1};
        tablo[4]  = '{1'b1, 32'h8000_1000, 32'hCAFE_BABE, 4'hF,    32'h0,         1'b1};
        tablo[5]  = '{1'b1, 32'h8000_0206, 32'hAABB_CCDD, 4'b1010, 32'h0,         1'b0};
        tablo[6]  = '{1'b0, 32'h8000_0207, 32'h0,         4'hF,    32'hAA34_CC78, 1'b0};
        tablo[7]  = '{1'b1, 32'h8000_0208, 32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0};
        tablo[8]  = '{1'b0, 32'h8000_0208, 32'h0,         4'hF,    32'h0BAD_F00D, 1'b0};
        tablo[9]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'hF,    32'h1357_9BDF, 1'b0};
        tablo[10] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF,    32'h0000_1111, 1'b0};
        tablo[11] = '{1'b0, 32'h8000_0201, 32'hFFFF_FFFF, 4'h0,    32'h0000_0200, 1'b0};

        rst_ana = 1'b0;
        bus.istek_gecerli = 1'b0; bus.istek_yaz = 1'b0; bus.istek_adres = '0;
        bus.istek_veri = '0; bus.istek_maske = '0;
        repeat (3) @(posedge clk);
        #1;
        kontrol("reset_hazir",   64'(bus.istek_hazir),   64'd1);
        kontrol("reset_gecerli", 64'(bus.cevap_gecerli), 64'd0);
        kontrol("reset_veri",    64'(bus.cevap_veri),    64'd0);
        kontrol("reset_hata",    64'(bus.cevap_hata),    64'd0);

        dut.bellek[128]  = 32'h0000_0200;
        dut.bellek[129]  = 32'hFFFF_FFFF;
        dut.bellek[130]  = 32'h0BAD_F00D;
        dut.bellek[0]    = 32'h0000_1111;
        dut.bellek[1023] = 32'h1357_9BDF;
        dut.bellek[192]  = 32'h5555_5555;
        @(negedge clk);
        rst_ana = 1'b1;

        for (int i = 0; i < 12; i++) begin
            islem(tablo[i].yaz, tablo[i].adres, tablo[i].veri, tablo[i].maske,
                  r_veri, r_hata, gec, darbe, dusuk);
            kontrol($sformatf("vek%0d_veri", i),    64'(r_veri), 64'(tablo[i].bek_veri));
            kontrol($sformatf("vek%0d_hata", i),    64'(r_hata), 64'(tablo[i].bek_hata));
            kontrol($sformatf("vek%0d_gecikme", i), 64'(gec),    64'd4);
            kontrol($sformatf("vek%0d_darbe", i),   64'(darbe),  64'd1);
            kontrol($sformatf("vek%0d_hazir0", i),  64'(dusuk),  64'd5);
        end
        kontrol("hata_yazma_satir0",    64'(dut.bellek[0]),    64'h0000_1111);
        kontrol("hata_yazma_satir1023", 64'(dut.bellek[1023]), 64'h1357_9BDF);

        // Reset dropped in the second wait cycle of a write.
        @(negedge clk);
        bus.istek_yaz = 1'b1; bus.istek_adres = 32'h8000_0300;
        bus.istek_veri = 32'hDEAD_BEEF; bus.istek_maske = 4'hF; bus.istek_gecerli = 1'b1;
        @(posedge clk);
        #1 bus.istek_gecerli = 1'b0;
        @(posedge clk);
        #2 rst_ana = 1'b0;
        #1;
        kontrol("rst_bekle_hazir",   64'(bus.istek_hazir),   64'd1);
        kontrol("rst_bekle_gecerli", 64'(bus.cevap_gecerli), 64'd0);
        darbe = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 2) rst_ana = 1'b1;
            if (bus.cevap_gecerli) darbe++;
        end
        kontrol("rst_bekle_darbe", 64'(darbe), 64'd0);
        kontrol("rst_bekle_satir", 64'(dut.bellek[192]), 64'h5555_5555);

        // Reset while the response pulse is high.
        @(negedge clk);
        bus.istek_yaz = 1'b0; bus.istek_adres = 32'h8000_0200; bus.istek_gecerli = 1'b1;
        @(posedge clk);
        #1 bus.istek_gecerli = 1'b0;
        goruldu = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.cevap_gecerli) begin goruldu = 1'b1; break; end
        end
        kontrol("rst_cevap_once", 64'(goruldu ? bus.cevap_veri : 32'hFFFF_FFFF), 64'h200);
        #1 rst_ana = 1'b0;
        #1;
        kontrol("rst_cevap_gecerli", 64'(bus.cevap_gecerli), 64'd0);
        kontrol("rst_cevap_veri",    64'(bus.cevap_veri),    64'd0);
        @(negedge clk);
        rst_ana = 1'b1;

        goruldu = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (g_sweep[0].bitti && g_sweep[1].bitti && g_sweep[2].bitti) begin
                goruldu = 1'b1; break;
            end
            @(negedge clk);
        end
        kontrol("sweep_bitti", 64'(goruldu), 64'd1);

        $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
`default_nettype wire
